// File: rtl/ssb_pkg.sv
// Shared definitions for the SSB sample aligner.
//   ssb_state_e   : aligner state (fill the delay line, then run)
//   MIN_MAX_DELAY : smallest legal buffer depth
//   is_pow2()     : elaboration-time check of the buffer depth
//   ch_lsb()      : LSB of channel ch in a packed multi-channel sample bus
package ssb_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } ssb_state_e;

    localparam int unsigned MIN_MAX_DELAY = 2;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned dw);
        return ch * dw;
    endfunction

endpackage

// File: rtl/sdp_ram_rbw.sv
// Simple dual-port RAM: one write port and one read port with a registered
// read. A read and a write to the same address in the same cycle return the
// old contents (read-before-write). The read register holds its value when
// rd_en_i is low and clears on reset; the array itself has no reset.
//   clk_i, reset_i          : clock, async active-high reset (read register only)
//   wr_en_i/wr_addr_i/wr_data_i : write port
//   rd_en_i/rd_addr_i       : read request, data on rd_data_o next cycle
module sdp_ram_rbw #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Non-blocking semantics give the pre-write entry on an address collision.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ssb_sample_aligner.sv
// Delays NUM_CH antenna streams by a programmable number of valid samples
// (not clock cycles) and carries the PSS peak as a per-sample tag so that
// SSB_start_o leaves together with the delayed sample it belongs to.
//   clk_i, reset_i     : clock, async active-high reset
//   s_axis_in_*        : input samples, channel c at [c*IN_DW +: IN_DW]
//   peak_i             : PSS peak pulse, tagged onto the current/next valid sample
//   delay_i/delay_load_i : new delay (clamped to MAX_DELAY), restarts the fill
//   m_axis_out_*       : delayed samples, one beat per accepted input once filled
//   SSB_start_o        : tag of the output beat, qualified by tvalid
//   filled_o           : delay line primed (RUN)
//   peak_overrun_o     : sticky, a peak merged into an already pending one
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_FILL | writing samples, no output until D samples are stored
// ST_RUN  | every accepted sample writes one entry and emits sample k-D
module ssb_sample_aligner
    import ssb_pkg::*;
#(
    parameter int unsigned IN_DW     = 32,
    parameter int unsigned NUM_CH    = 1,
    parameter int unsigned MAX_DELAY = 64,
    parameter int unsigned DELAY_W   = $clog2(MAX_DELAY + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [NUM_CH*IN_DW-1:0] s_axis_in_tdata,
    input  logic                    s_axis_in_tvalid,
    input  logic                    peak_i,
    input  logic [DELAY_W-1:0]      delay_i,
    input  logic                    delay_load_i,
    output logic [NUM_CH*IN_DW-1:0] m_axis_out_tdata,
    output logic                    m_axis_out_tvalid,
    output logic                    SSB_start_o,
    output logic                    filled_o,
    output logic                    peak_overrun_o
);

    localparam int unsigned DATA_W = NUM_CH * IN_DW;
    localparam int unsigned ENT_W  = DATA_W + 1;
    localparam int unsigned AW     = $clog2(MAX_DELAY);
    localparam bit MAX_DELAY_OK    = is_pow2(MAX_DELAY) && (MAX_DELAY >= MIN_MAX_DELAY);

    if (!MAX_DELAY_OK) begin : g_bad_max_delay
        $error("ssb_sample_aligner: MAX_DELAY must be a power of two >= 2");
    end

    ssb_state_e         state_q, state_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic [DELAY_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic               pend_q, pend_d;
    logic               ovr_q, ovr_d;
    logic               out_valid_q, out_valid_d;
    logic               sel_byp_q, sel_byp_d;
    logic [ENT_W-1:0]   byp_q, byp_d;

    logic [DELAY_W-1:0] delay_clamp;
    logic [ENT_W-1:0]   wr_entry;
    logic [ENT_W-1:0]   ram_rdata;
    logic [ENT_W-1:0]   out_entry;
    logic [AW-1:0]      rd_addr;
    logic               ram_rd_en;

    assign delay_clamp = (delay_i > DELAY_W'(MAX_DELAY)) ? DELAY_W'(MAX_DELAY) : delay_i;
    assign wr_entry    = {peak_i | pend_q, s_axis_in_tdata};
    // D = MAX_DELAY truncates to 0 here, so the read hits the entry being
    // overwritten and the RAM's read-before-write returns the oldest sample.
    assign rd_addr     = wr_ptr_q - delay_q[AW-1:0];

    always_comb begin
        state_d     = state_q;
        delay_d     = delay_q;
        fill_cnt_d  = fill_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        pend_d      = s_axis_in_tvalid ? 1'b0 : (pend_q | peak_i);
        ovr_d       = ovr_q | (peak_i & pend_q);
        out_valid_d = 1'b0;
        sel_byp_d   = sel_byp_q;
        byp_d       = byp_q;
        ram_rd_en   = 1'b0;

        if (s_axis_in_tvalid) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        if (delay_load_i) begin
            delay_d    = delay_clamp;
            // A sample accepted together with the load is the first of the new fill.
            fill_cnt_d = s_axis_in_tvalid ? DELAY_W'(1) : '0;
            state_d    = (fill_cnt_d >= delay_clamp) ? ST_RUN : ST_FILL;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (fill_cnt_q == delay_q) begin
                        state_d = ST_RUN;
                    end else if (s_axis_in_tvalid) begin
                        fill_cnt_d = fill_cnt_q + DELAY_W'(1);
                        if (fill_cnt_d == delay_q) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (s_axis_in_tvalid) begin
                        out_valid_d = 1'b1;
                        if (delay_q == '0) begin
                            sel_byp_d = 1'b1;
                            byp_d     = wr_entry;
                        end else begin
                            sel_byp_d = 1'b0;
                            ram_rd_en = 1'b1;
                        end
                    end
                end
                default: state_d = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_FILL;
            delay_q     <= '0;
            fill_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            pend_q      <= 1'b0;
            ovr_q       <= 1'b0;
            out_valid_q <= 1'b0;
            sel_byp_q   <= 1'b0;
            byp_q       <= '0;
        end else begin
            state_q     <= state_d;
            delay_q     <= delay_d;
            fill_cnt_q  <= fill_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            pend_q      <= pend_d;
            ovr_q       <= ovr_d;
            out_valid_q <= out_valid_d;
            sel_byp_q   <= sel_byp_d;
            byp_q       <= byp_d;
        end
    end

    sdp_ram_rbw #(
        .WIDTH (ENT_W),
        .DEPTH (MAX_DELAY),
        .AW    (AW)
    ) u_ram (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .wr_en_i   (s_axis_in_tvalid),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_entry),
        .rd_en_i   (ram_rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (ram_rdata)
    );

    // Both sources hold their value on idle cycles, so tdata holds as well.
    assign out_entry         = sel_byp_q ? byp_q : ram_rdata;
    assign m_axis_out_tdata  = out_entry[DATA_W-1:0];
    assign m_axis_out_tvalid = out_valid_q;
    assign SSB_start_o       = out_entry[DATA_W] & out_valid_q;
    assign filled_o          = (state_q == ST_RUN);
    assign peak_overrun_o    = ovr_q;

endmodule

// File: tb/tb_ssb_sample_aligner.sv
// Directed bench for ssb_sample_aligner with NUM_CH=2, IN_DW=16, MAX_DELAY=64.
// A sample-history model predicts every output beat; a few literal
// expectations pin the model.
module tb_ssb_sample_aligner;
    import ssb_pkg::*;

    localparam int unsigned IN_DW     = 16;
    localparam int unsigned NUM_CH    = 2;
    localparam int unsigned MAX_DELAY = 64;
    localparam int unsigned DELAY_W   = 7;
    localparam int unsigned DATA_W    = NUM_CH * IN_DW;

    logic               clk_i = 1'b0;
    logic               reset_i;
    logic [DATA_W-1:0]  s_axis_in_tdata;
    logic               s_axis_in_tvalid;
    logic               peak_i;
    logic [DELAY_W-1:0] delay_i;
    logic               delay_load_i;
    logic [DATA_W-1:0]  m_axis_out_tdata;
    logic               m_axis_out_tvalid;
    logic               SSB_start_o;
    logic               filled_o;
    logic               peak_overrun_o;

    always #5 clk_i = ~clk_i;

    ssb_sample_aligner #(
        .IN_DW     (IN_DW),
        .NUM_CH    (NUM_CH),
        .MAX_DELAY (MAX_DELAY),
        .DELAY_W   (DELAY_W)
    ) dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .s_axis_in_tdata   (s_axis_in_tdata),
        .s_axis_in_tvalid  (s_axis_in_tvalid),
        .peak_i            (peak_i),
        .delay_i           (delay_i),
        .delay_load_i      (delay_load_i),
        .m_axis_out_tdata  (m_axis_out_tdata),
        .m_axis_out_tvalid (m_axis_out_tvalid),
        .SSB_start_o       (SSB_start_o),
        .filled_o          (filled_o),
        .peak_overrun_o    (peak_overrun_o)
    );

    int checks = 0;
    int errors = 0;

    // Model: every accepted sample since time zero, with its tag.
    logic [DATA_W-1:0] hist_data [0:4095];
    bit                hist_tag  [0:4095];
    int                nacc;
    int                m_d;
    int                m_fill;
    bit                m_pend;
    bit                m_ovr;
    bit                exp_valid;
    bit                exp_tag;
    logic [DATA_W-1:0] exp_data;
    bit                cmp_en;
    int                ssb_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] mk(input int unsigned v);
        logic [DATA_W-1:0] r;
        logic [IN_DW-1:0]  s;
        s = IN_DW'(v);
        r = '0;
        r[ch_lsb(0, IN_DW) +: IN_DW] = s;
        r[ch_lsb(1, IN_DW) +: IN_DW] = ~s;
        return r;
    endfunction

    task automatic model_reset();
        m_d       = 0;
        m_fill    = 0;
        m_pend    = 1'b0;
        m_ovr     = 1'b0;
        exp_valid = 1'b0;
        exp_tag   = 1'b0;
        exp_data  = '0;
    endtask

    // Output after an accepted sample k is sample k-D, once D samples have
    // been accepted since the last load; a load cycle never produces output.
    task automatic model_step(input bit v, input logic [DATA_W-1:0] data, input bit pk,
                              input bit ld, input int unsigned dl);
        exp_valid = 1'b0;
        if (v) begin
            hist_data[nacc] = data;
            hist_tag[nacc]  = pk | m_pend;
        end
        if (pk && m_pend) m_ovr = 1'b1;
        m_pend = v ? 1'b0 : (m_pend | pk);
        if (ld) begin
            m_d    = (dl > MAX_DELAY) ? int'(MAX_DELAY) : int'(dl);
            m_fill = v ? 1 : 0;
        end else if (v) begin
            if (m_fill >= m_d) begin
                exp_valid = 1'b1;
                exp_data  = hist_data[nacc - m_d];
                exp_tag   = hist_tag[nacc - m_d];
            end
            m_fill++;
        end
        if (v) nacc++;
    endtask

    always @(negedge clk_i) begin
        if (cmp_en) begin
            chk("tvalid", m_axis_out_tvalid, exp_valid);
            chk("tdata", m_axis_out_tdata, exp_data);
            chk("ssb_start", SSB_start_o, exp_valid & exp_tag);
            chk("overrun", peak_overrun_o, m_ovr);
            if (SSB_start_o) ssb_log.push_back(int'(m_axis_out_tdata[IN_DW-1:0]));
        end
    end

    task automatic cyc(input bit v, input int unsigned val, input bit pk,
                       input bit ld, input int unsigned dl);
        logic [DATA_W-1:0] d;
        d = v ? mk(val) : mk(32'hDEAD);
        s_axis_in_tvalid = v;
        s_axis_in_tdata  = d;
        peak_i           = pk;
        delay_load_i     = ld;
        delay_i          = DELAY_W'(dl);
        @(posedge clk_i);
        model_step(v, d, pk, ld, dl);
        @(negedge clk_i);
        #1;
        s_axis_in_tvalid = 1'b0;
        peak_i           = 1'b0;
        delay_load_i     = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned r;
        int unsigned base;

        cmp_en           = 1'b0;
        reset_i          = 1'b1;
        s_axis_in_tdata  = '0;
        s_axis_in_tvalid = 1'b0;
        peak_i           = 1'b0;
        delay_i          = '0;
        delay_load_i     = 1'b0;
        nacc             = 0;
        model_reset();

        repeat (2) @(negedge clk_i);
        chk("rst_tvalid", m_axis_out_tvalid, 1'b0);
        chk("rst_tdata", m_axis_out_tdata, 32'h0);
        chk("rst_ssb", SSB_start_o, 1'b0);
        chk("rst_filled", filled_o, 1'b0);
        chk("rst_overrun", peak_overrun_o, 1'b0);
        #1 reset_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        chk("d0_after_reset_filled", filled_o, 1'b1);
        cmp_en = 1'b1;

        // D=5, continuous ramp with peaks at 20, idle peak before 30, two before 40
        cyc(0, 0, 0, 1, 5);
        chk("load5_filled_low", filled_o, 1'b0);
        r = 0;
        for (int i = 0; i < 60; i++) begin
            if (r == 30) cyc(0, 0, 1, 0, 0);
            if (r == 40) begin
                cyc(0, 0, 1, 0, 0);
                cyc(0, 0, 1, 0, 0);
            end
            cyc(1, r, (r == 20), 0, 0);
            if (i == 4) chk("no_out_before_6th", m_axis_out_tvalid, 1'b0);
            if (i == 5) begin
                chk("first_out_valid", m_axis_out_tvalid, 1'b1);
                chk("first_out_ch0", m_axis_out_tdata[15:0], 16'h0000);
                chk("first_out_ch1", m_axis_out_tdata[31:16], 16'hFFFF);
            end
            r++;
        end
        chk("ssb_count", ssb_log.size(), 3);
        chk("ssb_at_20", ssb_log[0], 20);
        chk("ssb_at_30", ssb_log[1], 30);
        chk("ssb_at_40", ssb_log[2], 40);
        chk("overrun_set", peak_overrun_o, 1'b1);

        // D=5, 40% valid duty
        for (int i = 0; i < 100; i++) begin
            while ($urandom_range(0, 99) >= 40) cyc(0, 0, 0, 0, 0);
            cyc(1, r, 0, 0, 0);
            r++;
        end

        // D=8 then reload D=3 while running, load coincides with a sample
        cyc(0, 0, 0, 1, 8);
        for (int i = 0; i < 20; i++) begin
            cyc(1, r, 0, 0, 0);
            r++;
        end
        chk("d8_filled", filled_o, 1'b1);
        base = r;
        cyc(1, base, 0, 1, 3);
        chk("reload_filled_low", filled_o, 1'b0);
        chk("reload_tvalid_low", m_axis_out_tvalid, 1'b0);
        cyc(1, base + 1, 0, 0, 0);
        cyc(1, base + 2, 0, 0, 0);
        chk("reload_silent_3", m_axis_out_tvalid, 1'b0);
        cyc(1, base + 3, 0, 0, 0);
        chk("reload_first_valid", m_axis_out_tvalid, 1'b1);
        chk("reload_first_data", m_axis_out_tdata[15:0], 16'(base));
        r = base + 4;
        for (int i = 0; i < 15; i++) begin
            cyc(1, r, 0, 0, 0);
            r++;
        end

        // D=0 passthrough with gaps
        cyc(0, 0, 0, 1, 0);
        chk("d0_filled", filled_o, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (i % 3 == 1) cyc(0, 0, 0, 0, 0);
            cyc(1, r, 0, 0, 0);
            chk("d0_passthrough", m_axis_out_tdata[15:0], 16'(r));
            r++;
        end

        // delay_i=100 clamps to 64; run through several pointer wraps
        cyc(0, 0, 0, 1, 100);
        base = r;
        for (int i = 0; i < 220; i++) begin
            cyc(1, r, 0, 0, 0);
            if (i == 63) chk("d64_silent", m_axis_out_tvalid, 1'b0);
            if (i == 64) begin
                chk("d64_first_valid", m_axis_out_tvalid, 1'b1);
                chk("d64_first_data", m_axis_out_tdata[15:0], 16'(base));
            end
            r++;
        end

        // tags in flight plus a pending peak, then an asynchronous reset
        cyc(1, r, 1, 0, 0);
        r++;
        cyc(1, r, 0, 0, 0);
        r++;
        cyc(0, 0, 1, 0, 0);
        cmp_en = 1'b0;
        @(posedge clk_i);
        #3 reset_i = 1'b1;
        #1;
        chk("mid_rst_tvalid", m_axis_out_tvalid, 1'b0);
        chk("mid_rst_tdata", m_axis_out_tdata, 32'h0);
        chk("mid_rst_ssb", SSB_start_o, 1'b0);
        chk("mid_rst_filled", filled_o, 1'b0);
        chk("mid_rst_overrun", peak_overrun_o, 1'b0);
        model_reset();
        #3 reset_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        cmp_en = 1'b1;

        cyc(0, 0, 0, 1, 4);
        for (int i = 0; i < 20; i++) begin
            cyc(1, r, 0, 0, 0);
            if (i == 3) chk("post_rst_silent", m_axis_out_tvalid, 1'b0);
            r++;
        end
        chk("post_rst_no_stale_tag", ssb_log.size(), 3);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
